// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM model.
// The lane merge serves both the array write and the port-1 bypass.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  localparam int MAX_DW = 1024;

  localparam logic [MAX_DW-1:0] ONE =
    {{(MAX_DW-1){1'b0}}, 1'b1};

  // Callers zero-extend into MAX_DW and truncate the result back.
  function automatic logic [MAX_DW-1:0] merge_wmask(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_DW-1:0] mask,
    input int                lane_w
  );
    logic [MAX_DW-1:0] bm;
    logic              lane;
    bm = '0;
    for (int i = MAX_DW - 1; i >= 0; i--) begin
      lane = |((mask >> (i / lane_w)) & ONE);
      bm   = {bm[MAX_DW-2:0], lane};
    end
    return (new_word & bm) | (old_word & ~bm);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: LAT register stages of data, valid and collision.
// Data stages load only behind a valid, so the output holds between reads.
module sram_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_coll,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          coll
);

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] c_q;
  logic [DW-1:0]  d_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      c_q[0] <= in_valid & in_coll;
      if (in_valid) d_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        c_q[i] <= c_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign dout  = d_q[LAT-1];
  assign valid = v_q[LAT-1];
  assign coll  = c_q[LAT-1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R synchronous SRAM with lane masks, read latency,
// port-1 write bypass and an optional post-reset clear sequencer.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WMASK_WIDTH    = 8,
  parameter int READ_LATENCY   = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH,
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic                  busy
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_bad_width
    $error("DATA_WIDTH exceeds merge helper width");
  end

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_nx;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  ready;
  logic                  wr0;
  logic                  rd0;
  logic                  rd1;
  logic                  hit;
  logic                  clr_we;
  logic [DATA_WIDTH-1:0] old0;
  logic [DATA_WIDTH-1:0] old1;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd1_data;
  logic                  coll0_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    busy       = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        busy       = 1'b1;
        clr_cnt_nx = clr_cnt + 1'b1;
        if (&clr_cnt) state_nx = ST_READY;
      end
      ST_READY: begin
      end
    endcase
  end

  assign ready  = (state == ST_READY) & ~rst;
  assign clr_we = (state == ST_CLEAR) & ~rst;
  assign wr0    = ready & ~csb0 & ~web0;
  assign rd0    = ready & ~csb0 & web0;
  assign rd1    = ready & ~csb1;
  assign hit    = wr0 & rd1 & (addr0 == addr1);

  assign old0 = mem[addr0];
  assign old1 = mem[addr1];

  assign wr_word = DATA_WIDTH'(merge_wmask(
    MAX_DW'(old0), MAX_DW'(din0),
    MAX_DW'(wmask0), WMASK_WIDTH));

  // Bypass forwards the merged word, so unmasked lanes stay old.
  assign rd1_data = (BYPASS != 0 && hit) ? wr_word : old1;

  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_cnt] <= '0;
    else if (wr0) mem[addr0] <= wr_word;
  end

  sram_rd_pipe #(
    .DW (DATA_WIDTH),
    .LAT(READ_LATENCY)
  ) u_pipe0 (
    .clk     (clk),
    .rst     (rst),
    .in_valid(rd0),
    .in_data (old0),
    .in_coll (1'b0),
    .dout    (dout0),
    .valid   (dout0_valid),
    .coll    (coll0_unused)
  );

  sram_rd_pipe #(
    .DW (DATA_WIDTH),
    .LAT(READ_LATENCY)
  ) u_pipe1 (
    .clk     (clk),
    .rst     (rst),
    .in_valid(rd1),
    .in_data (rd1_data),
    .in_coll (hit),
    .dout    (dout1),
    .valid   (dout1_valid),
    .coll    (collision)
  );

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench: two SRAM configurations share one stimulus stream,
// (latency 1 with bypass, latency 2 without) and are checked per port.
module tb_sram_1rw1r_param;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NM    = 4;
  localparam int DEPTH = 16;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          csb0   = 1'b1;
  logic          web0   = 1'b1;
  logic [NM-1:0] wmask0 = '0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] din0   = '0;
  logic          csb1   = 1'b1;
  logic [AW-1:0] addr1  = '0;

  logic [DW-1:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic          v0_a, v1_a, coll_a, busy_a;
  logic          v0_b, v1_b, coll_b, busy_b;

  sram_1rw1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(8),
    .READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .dout0_valid(v0_a),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1_a), .dout1_valid(v1_a),
    .collision(coll_a), .busy(busy_a)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(8),
    .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .dout0_valid(v0_b),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1_b), .dout1_valid(v1_b),
    .collision(coll_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    int            at;
  } exp_t;

  exp_t          q [4][$];
  logic [DW-1:0] last [4];
  logic [DW-1:0] model [DEPTH];
  int            cyc      = 0;
  int            total    = 0;
  int            bad      = 0;
  int            clr_left = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] o,
    input logic [DW-1:0] d,
    input logic [NM-1:0] m
  );
    logic [DW-1:0] r;
    r = o;
    for (int l = 0; l < NM; l++)
      if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
    return r;
  endfunction

  task automatic push(input int ch, input logic [DW-1:0] d,
                      input logic c, input int at);
    exp_t e;
    e.data = d;
    e.coll = c;
    e.at   = at;
    q[ch].push_back(e);
  endtask

  task automatic mon(input int ch, input logic v,
                     input logic [DW-1:0] d, input logic c,
                     input bit has_c);
    exp_t  e;
    string t;
    t = $sformatf("ch%0d@%0d", ch, cyc);
    if (q[ch].size() != 0 && q[ch][0].at == cyc) begin
      e = q[ch].pop_front();
      chk({t, " valid"}, DW'(v), DW'(1));
      chk({t, " data"}, d, e.data);
      if (has_c) chk({t, " coll"}, DW'(c), DW'(e.coll));
      last[ch] = e.data;
    end else begin
      chk({t, " idle valid"}, DW'(v), DW'(0));
      chk({t, " hold"}, d, last[ch]);
      if (has_c) chk({t, " idle coll"}, DW'(c), DW'(0));
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      mon(0, v0_a, dout0_a, 1'b0, 1'b0);
      mon(1, v1_a, dout1_a, coll_a, 1'b1);
      mon(2, v0_b, dout0_b, 1'b0, 1'b0);
      mon(3, v1_b, dout1_b, coll_b, 1'b1);
    end
  endtask

  task automatic cyc_loop();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic step(input logic c0, input logic w0,
                      input logic [NM-1:0] m0,
                      input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0,
                      input logic c1,
                      input logic [AW-1:0] a1);
    logic [DW-1:0] mg;
    logic          h;
    csb0 = c0; web0 = w0; wmask0 = m0;
    addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    chk("busy_a", DW'(busy_a), DW'(clr_left > 0));
    chk("busy_b", DW'(busy_b), DW'(clr_left > 0));
    if (clr_left > 0) begin
      clr_left--;
    end else begin
      mg = merge(model[a0], d0, m0);
      h  = !c0 && !w0 && !c1 && (a0 == a1);
      if (!c0 && w0) begin
        push(0, model[a0], 1'b0, cyc + 1);
        push(2, model[a0], 1'b0, cyc + 2);
      end
      if (!c1) begin
        push(1, h ? mg : model[a1], h, cyc + 1);
        push(3, model[a1], h, cyc + 2);
      end
      if (!c0 && !w0) model[a0] = mg;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 1'b1, '0, AW'(a), '0, 1'b0, AW'(a));
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d,
                    input logic [NM-1:0] m);
    step(1'b0, 1'b0, m, AW'(a), d, 1'b1, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      q[c].delete();
      last[c] = '0;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst busy_a", DW'(busy_a), DW'(1));
      chk("rst busy_b", DW'(busy_b), DW'(1));
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b0;
    clr_left = DEPTH;
  endtask

  initial begin
    fork
      monitor_loop();
      cyc_loop();
    join_none
    #1;
    do_reset(3);

    // requests during the clear are dropped
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 4'hF, AW'(i), 32'hFFFF0000 | DW'(i),
           1'b0, AW'(i));
    for (int i = 0; i < DEPTH; i++) rd(i);

    wr(5, 32'h11223344, 4'hF);
    wr(5, 32'hAABBCCDD, 4'b0101);
    rd(5);

    step(1'b0, 1'b0, 4'hF, 4'd7, 32'hDEADBEEF, 1'b0, 4'd7);
    step(1'b0, 1'b0, 4'hF, 4'd3, 32'h33333333, 1'b0, 4'd4);
    rd(6);
    step(1'b0, 1'b0, 4'h0, 4'd5, 32'h99999999, 1'b0, 4'd5);
    rd(7);

    for (int i = 0; i < 4; i++) wr(i, 32'hA0A0A000 + DW'(i), 4'hF);
    for (int i = 0; i < 4; i++) rd(i);
    repeat (4) idle();

    for (int i = 0; i < DEPTH; i++)
      wr(i, 32'h5A5A0000 | DW'(i * 17), 4'hF);
    rd(2);
    do_reset(2);
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b0, 4'hF, AW'(i), 32'hFFFFFFFF, 1'b0, AW'(i));
    do_reset(1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 4'hF, AW'(i), 32'hC0DE0000, 1'b0, AW'(i));
    for (int i = 0; i < DEPTH; i++) rd(i);
    repeat (4) idle();

    for (int c = 0; c < 4; c++)
      chk($sformatf("ch%0d drained", c), DW'(q[c].size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
Name: sram_1rw1r_param

Overview:
Parametrised synthesizable-style behavioural model of a 1RW+1R synchronous SRAM macro.
- Successor to the fixed 32x256 OpenRAM model: generic width, depth and write-mask granularity.
- Single clock; all activity on posedge only.
- Adds selectable read latency, per-port read-valid strobes, a write-to-read bypass on port 1, and an optional post-reset memory clear sequencer.
- Used as the scratchpad/enclave buffer RAM in simulation and FPGA flows.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH.
ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
WMASK_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH.
READ_LATENCY, 1, 1 or 2 cycles; any other value is an elaboration error.
BYPASS, 1, 1 = port-1 read of an address written the same cycle returns new data; 0 = returns old data.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = array contents untouched.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
csb0  in  1  port 0 chip select, active low
web0  in  1  port 0 write enable, active low
wmask0  in  NUM_WMASKS  port 0 lane write mask, 1 = write lane
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 read data
dout0_valid  out  1  one-cycle strobe; dout0 holds fresh data
csb1  in  1  port 1 chip select, active low
addr1  in  ADDR_WIDTH  port 1 address
dout1  out  DATA_WIDTH  port 1 read data
dout1_valid  out  1  one-cycle strobe; dout1 holds fresh data
collision  out  1  one-cycle strobe aligned with dout1_valid; port-1 read hit the address port 0 wrote at the same edge
busy  out  1  high while the clear sequencer runs; requests are dropped

Behaviour:
Reset (asynchronous, active-high):
- dout0, dout1 = 0; dout0_valid, dout1_valid, collision = 0.
- Read pipelines are flushed; in-flight reads never produce a valid strobe.
- State = CLEAR if CLEAR_ON_RESET = 1, else READY. Clear counter = 0.
- busy = 1 during reset when CLEAR_ON_RESET = 1, else 0.

State CLEAR:
- One word written to 0 per edge, addresses 0 to RAM_DEPTH-1; takes RAM_DEPTH edges.
- busy drops on the edge that writes the last address; the state moves to READY on that edge.
- While busy: csb0 and csb1 are ignored; no write, no read, no valid strobe.
- Reset asserted mid-clear restarts the clear at address 0.

State READY, port 0 (csb0 = 0 at edge N):
- Write (web0 = 0): for each lane i with wmask0[i] = 1, mem[addr0] lane i = din0 lane i at edge N. Lanes with wmask0[i] = 0 are untouched.
- A write with wmask0 = 0 is a legal no-op. Writes produce no dout0 change and no strobe.
- Read (web0 = 1): mem[addr0] as of before edge N is loaded into dout0 at edge N + READ_LATENCY - 1. dout0_valid is high for exactly the following cycle.

State READY, port 1 (csb1 = 0 at edge N):
- Read with the same timing as the port 0 read.
- If port 0 writes addr0 == addr1 at the same edge N:
  - BYPASS = 1: dout1 = masked merge; lanes with wmask0 = 1 come from din0, the rest from the old word.
  - BYPASS = 0: dout1 = old word.
  - collision pulses with dout1_valid in both modes.

Both ports:
- Outputs hold their last value when no read completes; they never go X.
- Back-to-back reads are accepted every cycle on both ports (fully pipelined).
- Port-0 and port-1 reads of the same address with no write at that edge carry no collision.

Decomposition:
- Package sram_pkg:
  - state enum {ST_CLEAR, ST_READY};
  - function merge_wmask(old, new, mask, lane width) used for both the write and the bypass.
  - Localparams NUM_WMASKS and RAM_DEPTH are derived in the module from these parameters.
- Sub-module sram_rd_pipe: READ_LATENCY-deep data+valid(+collision) register stage with async reset. Instantiated once per port.

Test Plan:
1. CLEAR_ON_RESET=1, ADDR_WIDTH=4: release rst -> busy high exactly 16 cycles. Then read addr 0..15 on both ports -> all dout = 0x00000000, one valid strobe per read.
2. Port-0 write addr 5, din 0xAABBCCDD, wmask 0b0101 over stored 0x11223344 -> port-1 read of 5 returns 0x11BB33DD one cycle later (READ_LATENCY=1), or two cycles later with READ_LATENCY=2.
3. Same-edge write addr 7 = 0xDEADBEEF (mask 0xF) plus port-1 read addr 7, old 0 -> BYPASS=1: dout1 = 0xDEADBEEF with collision=1; BYPASS=0: dout1 = 0x00000000 with collision=1.
4. Continuous reads addr 0,1,2,3 on consecutive cycles on both ports, READ_LATENCY=2 -> four consecutive valid strobes with matching data in order; dout stays stable after the last strobe.
5. Assert rst during clear at address 9 and while a read is in flight -> no valid strobe; dout = 0; clear restarts from 0 and busy lasts a full RAM_DEPTH cycles.
6. Issue write and read requests while busy = 1 -> no memory change (reads after clear return 0) and no strobes.
